// File: rtl/joy_md_pkg.sv
// ============================================================================
// joy_md_pkg : bit map and word type shared by the Megadrive joystick
//              conditioner and its debouncer.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package joy_md_pkg;

  localparam int JOY_R = 0;
  localparam int JOY_L = 1;
  localparam int JOY_D = 2;
  localparam int JOY_U = 3;
  localparam int JOY_A = 4;
  localparam int JOY_B = 5;
  localparam int JOY_C = 6;
  localparam int JOY_S = 7;
  localparam int JOY_X = 8;
  localparam int JOY_Y = 9;
  localparam int JOY_Z = 10;
  localparam int JOY_M = 11;
  localparam int JOY_W = 12;

  typedef logic [JOY_W-1:0] joy_word_t;

  // Opposite directions cancel each other instead of one taking priority.
  function automatic joy_word_t socd_clean(input joy_word_t v);
    joy_word_t r;
    r = v;
    if (v[JOY_L] && v[JOY_R]) begin
      r[JOY_L] = 1'b0;
      r[JOY_R] = 1'b0;
    end
    if (v[JOY_U] && v[JOY_D]) begin
      r[JOY_U] = 1'b0;
      r[JOY_D] = 1'b0;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/joy_md_debounce.sv
// ============================================================================
// joy_md_debounce : whole-vector debouncer; a word is committed only after it
//                   has held unchanged for DEB_TICKS ticks.
// Revision        : 1.0
// ============================================================================
`default_nettype none

module joy_md_debounce
  import joy_md_pkg::*;
#(
  parameter int DEB_TICKS = 5
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      tick,
  input  joy_word_t sync_word,
  output joy_word_t committed
);

  localparam logic [7:0] DEB_LAST = 8'(DEB_TICKS);

  joy_word_t  sample_q, sample_d;
  joy_word_t  commit_q, commit_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    sample_d = sample_q;
    cnt_d    = cnt_q;
    commit_d = commit_q;
    if (sync_word != sample_q) begin
      sample_d = sync_word;
      cnt_d    = '0;
    end else if (tick && (cnt_q != DEB_LAST)) begin
      cnt_d = cnt_q + 8'd1;
    end
    // Counter parks at DEB_LAST, so a held vector keeps re-committing itself.
    if (cnt_q == DEB_LAST) begin
      commit_d = sample_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_q <= '0;
      cnt_q    <= '0;
      commit_q <= '0;
    end else begin
      sample_q <= sample_d;
      cnt_q    <= cnt_d;
      commit_q <= commit_d;
    end
  end

  assign committed = commit_q;

endmodule

`default_nettype wire

// File: rtl/joy_md_conditioner.sv
// ============================================================================
// joy_md_conditioner : sync, debounce, SOCD clean, Mode+Start coin with masking
//                      and optional autofire (JOY_MD_AUTOFIRE_EN) per player.
// Revision           : 1.0
// ============================================================================
`default_nettype none

module joy_md_conditioner
  import joy_md_pkg::*;
#(
  parameter int TICK_DIV  = 24000,
  parameter int DEB_TICKS = 5,
  parameter int AF_TICKS  = 33
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [JOY_W-1:0] joystick1,
  input  logic [JOY_W-1:0] joystick2,
  output logic [JOY_W-1:0] p1_out,
  output logic [JOY_W-1:0] p2_out,
  output logic [1:0]       coin,
  output logic             tick
);

  localparam int             TW        = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;

  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tick_cnt_q <= '0;
    else        tick_cnt_q <= tick_cnt_d;
  end

  assign tick = (tick_cnt_q == TICK_LAST);

  joy_word_t raw_w [2];
  joy_word_t out_w [2];

  assign raw_w[0] = joystick1;
  assign raw_w[1] = joystick2;

  for (genvar p = 0; p < 2; p++) begin : g_player
    joy_word_t sync1_q, sync2_q;
    joy_word_t commit_w;
    joy_word_t af_word_w;
    joy_word_t out_q, out_d;
    logic      ms_w, ms_prev_q, coin_event_w;
    logic      mask_q, mask_d;
    logic      coin_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sync1_q <= '0;
        sync2_q <= '0;
      end else begin
        sync1_q <= raw_w[p];
        sync2_q <= sync1_q;
      end
    end

    joy_md_debounce #(
      .DEB_TICKS (DEB_TICKS)
    ) u_debounce (
      .clk       (clk),
      .rst_n     (rst_n),
      .tick      (tick),
      .sync_word (sync2_q),
      .committed (commit_w)
    );

`ifdef JOY_MD_AUTOFIRE_EN
    localparam logic [7:0] AF_LAST = 8'(AF_TICKS - 1);

    logic       af_held_w;
    logic       af_held_q;
    logic       af_phase_q, af_phase_d;
    logic [7:0] af_cnt_q, af_cnt_d;

    assign af_held_w = commit_w[JOY_X] | commit_w[JOY_Y];

    always_comb begin
      af_phase_d = af_phase_q;
      af_cnt_d   = af_cnt_q;
      if (!af_held_w) begin
        af_phase_d = 1'b0;
        af_cnt_d   = '0;
      end else if (!af_held_q) begin
        af_phase_d = 1'b1;
        af_cnt_d   = '0;
      end else if (tick) begin
        if (af_cnt_q == AF_LAST) begin
          af_phase_d = ~af_phase_q;
          af_cnt_d   = '0;
        end else begin
          af_cnt_d = af_cnt_q + 8'd1;
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        af_held_q  <= 1'b0;
        af_phase_q <= 1'b0;
        af_cnt_q   <= '0;
      end else begin
        af_held_q  <= af_held_w;
        af_phase_q <= af_phase_d;
        af_cnt_q   <= af_cnt_d;
      end
    end

    // The next-state phase is used so the first fire lands with the X/Y press.
    always_comb begin
      af_word_w        = commit_w;
      af_word_w[JOY_A] = commit_w[JOY_A] | (commit_w[JOY_X] & af_phase_d);
      af_word_w[JOY_B] = commit_w[JOY_B] | (commit_w[JOY_Y] & af_phase_d);
    end
`else
    assign af_word_w = commit_w;
`endif

    assign ms_w         = commit_w[JOY_M] & commit_w[JOY_S];
    assign coin_event_w = ms_w & ~ms_prev_q;

    always_comb begin
      mask_d = mask_q;
      if (coin_event_w) begin
        mask_d = 1'b1;
      end else if (!commit_w[JOY_M] && !commit_w[JOY_S]) begin
        mask_d = 1'b0;
      end
      out_d = socd_clean(af_word_w);
      // The event term hides M/S in the same cycle the mask is being set.
      if (mask_q || coin_event_w) begin
        out_d[JOY_M] = 1'b0;
        out_d[JOY_S] = 1'b0;
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        ms_prev_q <= 1'b0;
        mask_q    <= 1'b0;
        coin_q    <= 1'b0;
        out_q     <= '0;
      end else begin
        ms_prev_q <= ms_w;
        mask_q    <= mask_d;
        coin_q    <= coin_event_w;
        out_q     <= out_d;
      end
    end

    assign out_w[p] = out_q;
    assign coin[p]  = coin_q;
  end

  assign p1_out = out_w[0];
  assign p2_out = out_w[1];

endmodule

`default_nettype wire

// File: tb/tb_joy_md_conditioner.sv
// ============================================================================
// tb_joy_md_conditioner : directed table and sequence checks of the joystick
//                         conditioner with TICK_DIV=4, DEB_TICKS=3, AF_TICKS=2.
// Revision              : 1.0
// ============================================================================
`default_nettype none

module tb_joy_md_conditioner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] j1, j2;
  logic [11:0] p1_out, p2_out;
  logic [1:0]  coin;
  logic        tick;

  joy_md_conditioner #(
    .TICK_DIV  (4),
    .DEB_TICKS (3),
    .AF_TICKS  (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .joystick1 (j1),
    .joystick2 (j2),
    .p1_out    (p1_out),
    .p2_out    (p2_out),
    .coin      (coin),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Output monitors, sampled on the falling edge.
  int         coin_cnt0 = 0, coin_cnt1 = 0, coin_wide = 0;
  int         tick_cnt = 0, tick_wide = 0;
  logic [1:0] coin_prev = 2'b00;
  logic       tick_prev = 1'b0;
  bit         mon_chatter = 0, chatter_seen = 0;
  bit         mon_ms2 = 0, ms2_seen = 0;

  always @(negedge clk) begin
    if (coin[0]) coin_cnt0 <= coin_cnt0 + 1;
    if (coin[1]) coin_cnt1 <= coin_cnt1 + 1;
    if ((coin & coin_prev) != 2'b00) coin_wide <= coin_wide + 1;
    coin_prev <= coin;
    if (tick) tick_cnt <= tick_cnt + 1;
    if (tick && tick_prev) tick_wide <= tick_wide + 1;
    tick_prev <= tick;
    if (mon_chatter && p1_out[0]) chatter_seen <= 1'b1;
    if (mon_ms2 && (p2_out[11] || p2_out[7])) ms2_seen <= 1'b1;
  end

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [11:0] e1;
    logic [11:0] e2;
  } vec_t;

  vec_t tbl [7];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, base0, base1, wide0, rc, tk0;
    j1 = '0;
    j2 = '0;
    rst_n = 1'b0;
    cyc(3);
    check("reset_p1", p1_out, 0);
    check("reset_p2", p2_out, 0);
    check("reset_coin", coin, 0);
    check("reset_tick", tick, 0);
    rst_n = 1'b1;
    cyc(2);

    // 1: single button, latency window
    j1 = 12'h010;
    lat = 0;
    while (p1_out !== 12'h010 && lat < 40) begin
      cyc(1);
      lat++;
    end
    check("t1_p1_value", p1_out, 12'h010);
    check("t1_latency_max", (lat <= 19), 1);
    check("t1_latency_min", (lat >= 12), 1);
    check("t1_p2_idle", p2_out, 0);
    check("t1_no_coin", coin_cnt0 + coin_cnt1, 0);

    // tick strobe: period 4, one clock wide
    tk0 = tick_cnt;
    cyc(40);
    check("tick_count", tick_cnt - tk0, 10);
    check("tick_width", tick_wide, 0);

    // 2: chatter on R never commits
    mon_chatter = 1;
    for (int i = 0; i < 20; i++) begin
      j1[0] = ~j1[0];
      cyc(2);
    end
    j1 = 12'h010;
    cyc(30);
    mon_chatter = 0;
    cyc(1);
    check("t2_chatter_seen", chatter_seen, 0);
    check("t2_p1_after", p1_out, 12'h010);

    // 3: SOCD and general pass-through table
    tbl[0] = '{12'h003, 12'h000, 12'h000, 12'h000};
    tbl[1] = '{12'h00C, 12'h000, 12'h000, 12'h000};
    tbl[2] = '{12'h009, 12'h000, 12'h009, 12'h000};
    tbl[3] = '{12'h00F, 12'h000, 12'h000, 12'h000};
    tbl[4] = '{12'h006, 12'h030, 12'h006, 12'h030};
    tbl[5] = '{12'h040, 12'h00A, 12'h040, 12'h00A};
    tbl[6] = '{12'hC33, 12'h40C, 12'hC30, 12'h400};
    base0 = coin_cnt0 + coin_cnt1;
    for (int i = 0; i < 7; i++) begin
      j1 = tbl[i].j1;
      j2 = tbl[i].j2;
      cyc(30);
      check($sformatf("t3_p1_vec%0d", i), p1_out, tbl[i].e1);
      check($sformatf("t3_p2_vec%0d", i), p2_out, tbl[i].e2);
    end
    check("t3_no_coin", coin_cnt0 + coin_cnt1, base0);
    j1 = '0;
    j2 = '0;
    cyc(30);

    // 4: P2 coin, masking, re-press, partial release
    base0 = coin_cnt0;
    base1 = coin_cnt1;
    wide0 = coin_wide;
    mon_ms2 = 1;
    j2 = 12'h880;
    cyc(80);
    check("t4_one_pulse", coin_cnt1 - base1, 1);
    check("t4_p2_masked", p2_out, 12'h000);
    j2 = 12'h000;
    cyc(30);
    j2 = 12'h880;
    cyc(30);
    check("t4_repress_pulse", coin_cnt1 - base1, 2);
    j2 = 12'h800;
    cyc(30);
    check("t4_m_still_masked", p2_out, 12'h000);
    j2 = 12'h000;
    cyc(30);
    mon_ms2 = 0;
    cyc(1);
    check("t4_ms_never_out", ms2_seen, 0);
    check("t4_pulse_width", coin_wide - wide0, 0);
    check("t4_no_p1_coin", coin_cnt0 - base0, 0);
    j2 = 12'h800;
    cyc(30);
    check("t4_mask_cleared", p2_out, 12'h800);
    j2 = 12'h000;
    cyc(30);

    // 5: reset in the middle of an M+S hold
    base0 = coin_cnt0;
    j1 = 12'h880;
    cyc(30);
    check("t5_first_pulse", coin_cnt0 - base0, 1);
    rst_n = 1'b0;
    #1;
    check("t5_async_p1", p1_out, 0);
    check("t5_async_coin", coin, 0);
    cyc(2);
    rc = coin_cnt0;
    cyc(6);
    check("t5_no_pulse_in_reset", coin_cnt0, rc);
    rst_n = 1'b1;
    lat = 0;
    while (coin_cnt0 == rc && lat < 40) begin
      cyc(1);
      lat++;
    end
    check("t5_pulse_after_reset", coin_cnt0 - rc, 1);
    check("t5_pulse_latency", (lat >= 12 && lat < 40), 1);
    cyc(40);
    check("t5_single_pulse", coin_cnt0 - rc, 1);
    j1 = 12'h000;
    cyc(30);

    // 6: autofire on X
    j1 = 12'h100;
`ifdef JOY_MD_AUTOFIRE_EN
    lat = 0;
    while (p1_out[8] !== 1'b1 && lat < 40) begin
      cyc(1);
      lat++;
    end
    check("t6_x_committed", p1_out[8], 1);
    check("t6_first_fire", p1_out[4], 1);
    lat = 0;
    while (p1_out[4] === 1'b1 && lat < 20) begin
      cyc(1);
      lat++;
    end
    lat = 0;
    while (p1_out[4] === 1'b0 && lat < 20) begin
      cyc(1);
      lat++;
    end
    check("t6_low_run", lat, 8);
    lat = 0;
    while (p1_out[4] === 1'b1 && lat < 20) begin
      cyc(1);
      lat++;
    end
    check("t6_high_run", lat, 8);
    j1 = 12'h000;
    cyc(30);
    check("t6_release", p1_out, 12'h000);
`else
    cyc(30);
    check("t6_x_plain_a", p1_out, 12'h100);
    cyc(17);
    check("t6_x_plain_b", p1_out, 12'h100);
    cyc(13);
    check("t6_x_plain_c", p1_out, 12'h100);
    j1 = 12'h000;
    cyc(30);
    check("t6_release", p1_out, 12'h000);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
